// File: rtl/feynman_cascade_decoder.sv
// Bit-serial inverse of a Feynman (CNOT) ripple cascade.
// Resolves x[k] = y[k]^y[k-1] one bit per clock and hands the word out over valid/ready.
module feynman_cascade_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_parity,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] y_cap;
    logic [WIDTH-1:0] x_full;

    // Every decoded bit is available from the captured word; the serial
    // loop below only chooses which one lands in out_word this cycle.
    assign x_full = y_cap ^ {y_cap[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            y_cap      <= '0;
            out_word   <= '0;
            out_parity <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_cap    <= in_word;
                        out_word <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_word[cnt] <= x_full[cnt];
                    if (cnt == CW'(WIDTH - 1)) begin
                        out_parity <= y_cap[WIDTH-1];
                        state      <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state == RUN) || (state == HOLD);

endmodule

// File: tb/tb_feynman_cascade_decoder.sv
// Self-checking bench for feynman_cascade_decoder (WIDTH=8): vector table,
// handshake corner sequences, exhaustive and randomized words against a cascade model.
module tb_feynman_cascade_decoder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_word;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic         out_parity;
    logic         busy;

    int total = 0;
    int bad   = 0;

    feynman_cascade_decoder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_parity (out_parity),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] x;
        logic         par;
    } vec_t;

    // Forward Feynman cascade: each output bit is the running XOR of inputs.
    function automatic logic [W-1:0] encode(input logic [W-1:0] x);
        logic [W-1:0] y;
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            acc  = acc ^ x[i];
            y[i] = acc;
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Feed one word and wait for the result; ends with the output consumed.
    task automatic run_word(input logic [W-1:0] y, output logic [W-1:0] w,
                            output logic p, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_word  = y;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        w = out_word;
        p = out_parity;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t         tbl[3];
    logic [W-1:0] w, hold_w;
    logic         p, hold_p;
    int           lat;

    initial begin
        int acc_c[2];
        logic [W-1:0] outs[2];
        int na, no;
        logic [W-1:0] x;

        tbl[0] = '{y: 8'hFF, x: 8'h01, par: 1'b1};
        tbl[1] = '{y: 8'h0F, x: 8'h11, par: 1'b0};
        tbl[2] = '{y: 8'hAA, x: 8'hFE, par: 1'b1};

        in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_out_word",  32'(out_word),   32'd0);
        chk("rst_parity",    32'(out_parity), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            run_word(tbl[i].y, w, p, lat);
            chk("tbl_word",    32'(w),   32'(tbl[i].x));
            chk("tbl_parity",  32'(p),   32'(tbl[i].par));
            chk("tbl_latency", 32'(lat), 32'd8);
        end

        // Backpressure: stall in HOLD with a competing input offered.
        in_valid = 1'b1; in_word = 8'h0F;
        @(posedge clk); #1;
        in_word = 8'h55;
        for (int i = 0; i < 8; i++) begin
            chk("bp_busy_run", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        hold_w = out_word; hold_p = out_parity;
        chk("bp_word", 32'(hold_w), 32'h11);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_stable_word",  32'(out_word),   32'(hold_w));
            chk("bp_stable_par",   32'(out_parity), 32'(hold_p));
            chk("bp_in_ready_low", 32'(in_ready),   32'd0);
            chk("bp_valid_held",   32'(out_valid),  32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_ready", 32'(in_ready),  32'd1);
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_not_taken",  32'(busy),      32'd0);
        chk("bp_word_kept",  32'(out_word),  32'h11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_55", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_55_word",   32'(out_word),   32'hFF);
        chk("bp_55_parity", 32'(out_parity), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        na = 0; no = 0;
        in_valid = 1'b1; in_word = 8'h0F; out_ready = 1'b1;
        for (int c = 0; c < 40 && no < 2; c++) begin
            logic acc_now;
            acc_now = in_ready && in_valid;
            if (acc_now) acc_c[na] = c;
            if (out_valid) begin
                outs[no] = out_word;
                no++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                na++;
                if (na == 1) in_word = 8'hFF;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_accepts", 32'(na), 32'd2);
        chk("b2b_outputs", 32'(no), 32'd2);
        if (na == 2) chk("b2b_period", 32'(acc_c[1] - acc_c[0]), 32'd10);
        if (no == 2) begin
            chk("b2b_out0", 32'(outs[0]), 32'h11);
            chk("b2b_out1", 32'(outs[1]), 32'h01);
        end
        @(posedge clk); #1;

        // Reset in the middle of RUN (counter = 3).
        in_valid = 1'b1; in_word = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_word",  32'(out_word),  32'd0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_in_ready",  32'(in_ready),  32'd1);
        chk("mid_busy_low",  32'(busy),      32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(8'hAA, w, p, lat);
        chk("mid_after_word",   32'(w), 32'hFE);
        chk("mid_after_parity", 32'(p), 32'd1);

        // Exhaustive: every x through the forward cascade and back.
        for (int v = 0; v < 256; v++) begin
            x = W'(v);
            run_word(encode(x), w, p, lat);
            chk("exh_word",   32'(w), 32'(x));
            chk("exh_parity", 32'(p), 32'(^x));
        end

        // Random words with random stall lengths in HOLD.
        for (int n = 0; n < 30; n++) begin
            int stall;
            x = W'($urandom);
            stall = int'($urandom_range(0, 4));
            in_valid = 1'b1; in_word = encode(x);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            out_ready = 1'b0;
            lat = 0;
            while (!out_valid && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            chk("rnd_latency", 32'(lat), 32'd8);
            repeat (stall) @(posedge clk);
            #1;
            chk("rnd_word",   32'(out_word),   32'(x));
            chk("rnd_parity", 32'(out_parity), 32'(^x));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feynman_cascade_decoder.md
# feynman_cascade_decoder

Bit-serial inverse of a Feynman-gate (CNOT) cascade. A WIDTH-bit word encoded by a ripple of Feynman gates, y[i] = x[0]^x[1]^…^x[i], is accepted over a valid/ready handshake. The block recovers x[0] = y[0], x[i] = y[i]^y[i-1] one bit per clock and presents the decoded word on a second valid/ready port. It sits downstream of the team's Feynman-gate encoders and uncomputes their output back to the original operands, plus a parity bit.

## Interface
- WIDTH, default 8: word width in bits; legal range WIDTH >= 2.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block can accept a word; equals (state == IDLE).
- in_word  input  WIDTH  encoded word y.
- out_valid  output  1  out_word and out_parity are valid.
- out_ready  input  1  downstream accepts the output.
- out_word  output  WIDTH  decoded word x.
- out_parity  output  1  y[WIDTH-1], which equals XOR of all x bits.
- busy  output  1  high in RUN or HOLD.

## Operation
- **FSM states:** IDLE, RUN, HOLD. The state, bit counter (clog2(WIDTH) bits), captured y and out_word are registers.
- **IDLE:**
  - in_ready=1.
  - On in_valid && in_ready at an edge:
    - capture in_word;
    - clear out_word to 0;
    - counter <= 0;
    - go to RUN.
- **RUN:**
  - Each edge resolves bit k = counter:
    - out_word[0] <= y[0] when k=0;
    - out_word[k] <= y[k]^y[k-1] otherwise.
  - The counter increments after each bit.
  - On the edge resolving k = WIDTH-1, go to HOLD and set out_parity <= y[WIDTH-1].
  - in_valid is ignored in RUN.
- **HOLD:**
  - out_valid=1; out_word and out_parity stay stable.
  - On out_ready=1 at an edge, go to IDLE; out_word keeps its value.
  - in_valid is ignored in HOLD. There is no same-cycle accept, because in_ready is low in HOLD.
- **Arithmetic:** XOR only. No carries, no width growth.
- **Boundaries:**
  - The counter never wraps: the RUN exit happens at WIDTH-1, before wrap.
  - An in_word change after acceptance has no effect.
  - out_ready is a don't-care outside HOLD.
  - in_valid together with out_ready in HOLD: only the HOLD→IDLE transition occurs; the word is accepted no earlier than the following edge.
- **Reset (rst_n low, any state, including mid-RUN):**
  - immediately forces IDLE;
  - clears the counter, captured y, out_word=0, out_parity=0;
  - out_valid=0, busy=0, in_ready=1;
  - discards a partially decoded word.

## Timing
- **Reset values:** in_ready=1, out_valid=0, busy=0, out_word=0, out_parity=0.
- **Latency:** acceptance at edge E0. Bits resolve at E1..E_WIDTH. out_valid rises after E_WIDTH (WIDTH cycles after acceptance).
- **Throughput:** with out_ready held high, the next accept is possible at E_(WIDTH+2). The minimum word period is WIDTH+2 cycles.
- **Visibility of partial results:** out_word bits become visible one per cycle during RUN. Only values sampled while out_valid=1 are meaningful to consumers.
- **Output timing:** in_ready, out_valid and busy are decoded from the registered state; there are no combinational input-to-output paths.

## Test plan (WIDTH=8)
- **Reset:** assert rst_n=0 → in_ready=1, out_valid=0, busy=0, out_word=8'h00, out_parity=0.
- **Single words:**
  - in_word=8'hFF → out_word=8'h01, out_parity=1.
  - in_word=8'h0F → out_word=8'h11, out_parity=0.
  - in_word=8'hAA → out_word=8'hFE, out_parity=1.
  - In each case out_valid rises exactly 8 cycles after the accept edge.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles in HOLD → out_word and out_parity stay stable, in_ready=0.
  - A new in_valid/in_word (8'h55) is not accepted until after the HOLD→IDLE edge.
- **Back-to-back:** keep in_valid=1 and out_ready=1 with words 8'h0F then 8'hFF → accepts are 10 cycles apart; outputs 8'h11 then 8'h01.
- **Mid-operation reset:** drop rst_n during RUN at counter=3 → out_word=0, out_valid=0, in_ready=1 immediately. A subsequent 8'hAA decodes to 8'hFE.
- **Exhaustive check:** all 256 x values, encoded to y by a bench Feynman cascade → decoded out_word == x and out_parity == ^x for every word.
